// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART responder on the data_sram bus (DATA 0xBFD003F8, STATUS 0xBFD003FC)
//   clk, reset (sync, active-high)
//   data_sram_en/we/addr/wdata  : request in; data_sram_rdata : registered read data (1-cycle latency)
//   uart_hit                    : combinational address decode for the arbiter
//   uart_txd / uart_rxd         : serial line (rxd asynchronous)
//   UART_RX_FIFO_EN             : when defined, the receive holding register becomes a 4-entry FIFO
module uart_mmio #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        uart_hit,
    output logic        uart_txd,
    input  logic        uart_rxd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam logic [15:0] DM1 = 16'(DIV - 1);
    localparam logic [15:0] HM1 = 16'(DIV / 2 - 1);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;
    logic is_data, is_stat, wr, rd, rd_data, rd_stat;
    assign is_data  = data_sram_addr == 32'hBFD0_03F8;
    assign is_stat  = data_sram_addr == 32'hBFD0_03FC;
    assign uart_hit = data_sram_en && (is_data || is_stat);
    assign wr       = uart_hit && |data_sram_we;
    assign rd       = uart_hit && ~|data_sram_we;
    assign rd_data  = rd && is_data;
    assign rd_stat  = rd && is_stat;
    logic unused;
    assign unused = ^data_sram_wdata[31:8];
    st_t ts;
    logic [15:0] tcnt;
    logic [2:0] tbit;
    logic [7:0] tsh;
    logic tx_ready, tx_go;
    assign tx_ready = ts == S_IDLE;
    // the last STOP cycle also accepts, so back-to-back frames have no idle gap
    assign tx_go = wr && is_data && (tx_ready || (ts == S_STOP && tcnt == DM1));
    always_ff @(posedge clk) begin
        if (reset) begin
            ts <= S_IDLE;
            tcnt <= '0;
            tbit <= '0;
            tsh <= '0;
            uart_txd <= 1'b1;
        end else if (tx_go) begin
            ts <= S_START;
            tcnt <= '0;
            tsh <= data_sram_wdata[7:0];
            uart_txd <= 1'b0;
        end else if (ts != S_IDLE) begin
            if (tcnt != DM1) tcnt <= tcnt + 16'd1;
            else begin
                tcnt <= '0;
                case (ts)
                    S_START: begin
                        ts <= S_DATA;
                        tbit <= '0;
                        uart_txd <= tsh[0];
                        tsh <= tsh >> 1;
                    end
                    S_DATA: begin
                        ts <= tbit == 3'd7 ? S_STOP : S_DATA;
                        tbit <= tbit + 3'd1;
                        uart_txd <= tbit == 3'd7 ? 1'b1 : tsh[0];
                        tsh <= tsh >> 1;
                    end
                    default: ts <= S_IDLE;
                endcase
            end
        end
    end
    st_t rs;
    logic [15:0] rcnt;
    logic [2:0] rbit;
    logic [7:0] rsh;
    logic s1, s2, s3, commit;
    assign commit = rs == S_STOP && rcnt == DM1 && s2;
    always_ff @(posedge clk) begin
        if (reset) begin
            {s1, s2, s3} <= 3'b111;
            rs <= S_IDLE;
            rcnt <= '0;
            rbit <= '0;
            rsh <= '0;
        end else begin
            s1 <= uart_rxd;
            s2 <= s1;
            s3 <= s2;
            case (rs)
                S_IDLE: begin
                    rcnt <= '0;
                    if (s3 && !s2) rs <= S_START;
                end
                S_START: begin
                    rcnt <= rcnt == HM1 ? '0 : rcnt + 16'd1;
                    rbit <= '0;
                    if (rcnt == HM1) rs <= s2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    rcnt <= rcnt == DM1 ? '0 : rcnt + 16'd1;
                    if (rcnt == DM1) begin
                        rsh <= {s2, rsh[7:1]};
                        rbit <= rbit + 3'd1;
                        if (rbit == 3'd7) rs <= S_STOP;
                    end
                end
                default: begin
                    rcnt <= rcnt == DM1 ? '0 : rcnt + 16'd1;
                    if (rcnt == DM1) rs <= S_IDLE;
                end
            endcase
        end
    end
    logic rx_valid, ovr_set, overrun;
    logic [7:0] rx_head;
`ifdef UART_RX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wp, rp;
    logic [2:0] fcnt;
    logic push, pop, full;
    assign full     = fcnt == 3'd4;
    assign pop      = rd_data && fcnt != 3'd0;
    assign push     = commit && (!full || pop);
    assign ovr_set  = commit && full && !pop;
    assign rx_valid = fcnt != 3'd0;
    assign rx_head  = mem[rp];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            fcnt <= '0;
        end else begin
            if (push) mem[wp] <= rsh;
            wp <= push ? wp + 2'd1 : wp;
            rp <= pop ? rp + 2'd1 : rp;
            fcnt <= fcnt + {2'b0, push} - {2'b0, pop};
        end
    end
`else
    logic [7:0] rx_byte;
    logic rx_full;
    // a commit racing a DATA read keeps the byte valid and is not an overrun
    assign ovr_set  = commit && rx_full && !rd_data;
    assign rx_valid = rx_full;
    assign rx_head  = rx_byte;
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte <= '0;
            rx_full <= 1'b0;
        end else begin
            rx_byte <= commit ? rsh : rx_byte;
            rx_full <= commit ? 1'b1 : (rd_data ? 1'b0 : rx_full);
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= '0;
            overrun <= 1'b0;
        end else begin
            if (rd) data_sram_rdata <= is_data ? {24'b0, rx_head} : {29'b0, overrun, rx_valid, tx_ready};
            overrun <= ovr_set ? 1'b1 : (rd_stat ? 1'b0 : overrun);
        end
    end
endmodule
